any1_decode_queue: RTL and testbench

//  Elastic FIFO between the decoder output (sDecode) and the register-fetch/issue stage.

---
 rtl/any1_decode_queue.sv | 111 +++++++++++
 tb/tb_any1_decode_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_decode_queue.sv
// any1_decode_queue: elastic FIFO between the decoder and the register-fetch/issue stage.
// Records are opaque and pass through bit-exact. A flush drops every entry and any
// push in the same cycle.

package any1_decode_queue_pkg;

  // Decoded instruction record handed from decode to issue
  typedef struct packed {
    logic        ui;             // unimplemented instruction
    logic [2:0]  Stream;         // fetch stream tag
    logic        predict_taken;  // branch predictor direction
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [63:0] imm;
    logic        rfwr;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
  } sDecode;

endpackage

module any1_decode_queue
  import any1_decode_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          din_v_i,
  input  sDecode        din_i,
  output logic          din_rdy_o,
  output logic          dout_v_o,
  output sDecode        dout_o,
  input  logic          dout_rdy_i,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  sDecode        r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the occupancy count only; pointers are equal in both cases.
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // Ready ignores dout_rdy_i, so a full queue refuses input even while popping.
  assign w_push  = din_v_i & ~w_full  & ~flush_i;
  assign w_pop   = ~w_empty & dout_rdy_i & ~flush_i;

  assign din_rdy_o = ~w_full;
  assign dout_v_o  = ~w_empty;
  assign dout_o    = r_mem[r_rp];
  assign count_o   = r_count;
  assign full_o    = w_full;
  assign empty_o   = w_empty;

  // Storage write; contents need no reset because validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wp] <= din_i;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy never exceeds capacity
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_count <= DEPTH_CNT);
  // No write into a full queue
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));
  // No read from an empty queue
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(w_pop && w_empty));

endmodule

// File: tb/tb_any1_decode_queue.sv
// Self-checking bench for any1_decode_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_any1_decode_queue;
  import any1_decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst;
  logic   flush;
  logic   din_v;
  sDecode din;
  logic   din_rdy;
  logic   dout_v;
  sDecode dout;
  logic   dout_rdy;
  logic [2:0] count;
  logic   full;
  logic   empty;

  int checks = 0;
  int errors = 0;

  sDecode mq[$];

  any1_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .din_v_i    (din_v),
    .din_i      (din),
    .din_rdy_o  (din_rdy),
    .dout_v_o   (dout_v),
    .dout_o     (dout),
    .dout_rdy_i (dout_rdy),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always #5 clk = ~clk;

  function automatic sDecode rand_rec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return sDecode'(r[$bits(sDecode)-1:0]);
  endfunction

  // Drive one cycle of inputs, advance one edge, update the reference model, settle.
  task automatic cycle(input logic r, input logic f, input logic v, input sDecode d, input logic rd);
    bit can_push;
    bit can_pop;
    rst      = r;
    flush    = f;
    din_v    = v;
    din      = d;
    dout_rdy = rd;
    can_push = (mq.size() < DEPTH);
    can_pop  = (mq.size() > 0);
    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else begin
      if (can_pop && rd) void'(mq.pop_front());
      if (v && can_push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] st;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    st = {dout_v, empty, full, din_rdy, count};
    checks++;
    if (st !== {1'b0, 1'b1, 1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL reset_status got %b exp %b", st, {1'b0, 1'b1, 1'b0, 1'b1, 3'd0});
    end
  endtask

  sDecode a [3];

  task automatic test_fill_order();
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_rec();
      cycle(1'b0, 1'b0, 1'b1, a[i], 1'b0);
      checks++;
      if (count !== 3'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1);
      end
      checks++;
      if (dout_v !== 1'b1 || dout !== a[0]) begin
        errors++; $display("FAIL fill_head[%0d] got v=%b %h exp v=1 %h", i, dout_v, dout, a[0]);
      end
    end
  endtask

  task automatic test_full_refuse();
    sDecode d;
    sDecode e;
    sDecode exp_q [4];
    d = rand_rec();
    e = rand_rec();
    cycle(1'b0, 1'b0, 1'b1, d, 1'b0);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || din_rdy !== 1'b0) begin
      errors++; $display("FAIL full_flags got cnt=%0d full=%b rdy=%b exp 4 1 0", count, full, din_rdy);
    end
    cycle(1'b0, 1'b0, 1'b1, e, 1'b1);
    checks++;
    if (count !== 3'd3 || full !== 1'b0 || dout !== a[1]) begin
      errors++; $display("FAIL full_pop_refuse got cnt=%0d full=%b head=%h exp 3 0 %h", count, full, dout, a[1]);
    end
    cycle(1'b0, 1'b0, 1'b1, e, 1'b0);
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin
      errors++; $display("FAIL full_accept_later got cnt=%0d full=%b exp 4 1", count, full);
    end
    exp_q = '{a[1], a[2], d, e};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout !== exp_q[i]) begin
        errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, dout, exp_q[i]);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || dout_v !== 1'b0) begin
      errors++; $display("FAIL drain_empty got cnt=%0d empty=%b v=%b exp 0 1 0", count, empty, dout_v);
    end
  endtask

  task automatic test_stream();
    sDecode s [10];
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s[i] = rand_rec();
      cycle(1'b0, 1'b0, 1'b1, s[i], 1'b1);
      checks++;
      if (count !== 3'd1 || dout !== s[i]) begin
        errors++; $display("FAIL stream[%0d] got cnt=%0d head=%h exp 1 %h", i, count, dout, s[i]);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL stream_end got cnt=%0d empty=%b exp 0 1", count, empty);
    end
  endtask

  task automatic test_flush();
    sDecode y;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, rand_rec(), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, rand_rec(), 1'b1);
    checks++;
    if ({dout_v, empty, din_rdy, count} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
      errors++; $display("FAIL flush_status got v=%b e=%b rdy=%b cnt=%0d exp 0 1 1 0", dout_v, empty, din_rdy, count);
    end
    y = rand_rec();
    cycle(1'b0, 1'b0, 1'b1, y, 1'b0);
    checks++;
    if (count !== 3'd1 || dout !== y) begin
      errors++; $display("FAIL flush_next_push got cnt=%0d head=%h exp 1 %h", count, dout, y);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (count !== 3'd0 || dout_v !== 1'b0) begin
      errors++; $display("FAIL flush_no_dup got cnt=%0d v=%b exp 0 0", count, dout_v);
    end
  endtask

  task automatic test_reset_mid();
    sDecode y;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, rand_rec(), 1'b0);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL rmid_full got %b exp 1", full);
    end
    cycle(1'b1, 1'b1, 1'b1, rand_rec(), 1'b1);
    checks++;
    if ({dout_v, empty, full, din_rdy, count} !== {1'b0, 1'b1, 1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL rmid_status got %b exp %b", {dout_v, empty, full, din_rdy, count}, {1'b0, 1'b1, 1'b0, 1'b1, 3'd0});
    end
    y = rand_rec();
    cycle(1'b0, 1'b0, 1'b1, y, 1'b0);
    checks++;
    if (count !== 3'd1 || dout_v !== 1'b1 || dout !== y) begin
      errors++; $display("FAIL rmid_push got cnt=%0d v=%b head=%h exp 1 1 %h", count, dout_v, dout, y);
    end
  endtask

  task automatic test_random();
    sDecode cur;
    bit     held;
    bit     r, f, v, rd;
    bit     refused;
    held = 1'b0;
    cur  = '0;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int n = 0; n < 10000; n++) begin
      r  = ($urandom_range(499) == 0);
      f  = ($urandom_range(99) < 2);
      rd = 1'($urandom_range(1));
      if (held) begin
        v = 1'b1;
      end else begin
        v   = 1'($urandom_range(1));
        cur = rand_rec();
      end
      refused = v && (mq.size() == DEPTH) && !f && !r;
      cycle(r, f, v, cur, rd);
      held = refused;
      checks++;
      if (count !== 3'(mq.size())) begin
        errors++; $display("FAIL rnd_count @%0d got %0d exp %0d", n, count, mq.size());
      end
      checks++;
      if ({full, empty, din_rdy, dout_v} !== {mq.size() == DEPTH, mq.size() == 0, mq.size() != DEPTH, mq.size() != 0}) begin
        errors++; $display("FAIL rnd_flags @%0d got %b exp %b", n, {full, empty, din_rdy, dout_v},
                           {mq.size() == DEPTH, mq.size() == 0, mq.size() != DEPTH, mq.size() != 0});
      end
      if (mq.size() > 0) begin
        checks++;
        if (dout.ui !== mq[0].ui || dout.Stream !== mq[0].Stream || dout.predict_taken !== mq[0].predict_taken) begin
          errors++; $display("FAIL rnd_fields @%0d got %b/%h/%b exp %b/%h/%b", n, dout.ui, dout.Stream,
                             dout.predict_taken, mq[0].ui, mq[0].Stream, mq[0].predict_taken);
        end
        checks++;
        if (dout !== mq[0]) begin
          errors++; $display("FAIL rnd_record @%0d got %h exp %h", n, dout, mq[0]);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    din_v    = 1'b0;
    din      = '0;
    dout_rdy = 1'b0;
    mq.delete();
    test_reset();
    test_fill_order();
    test_full_refuse();
    test_stream();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
